// File: rtl/rs_multi_pkg.sv
// Shared opcode and tag constants for the reservation station, ROB, decoder and ALU.
package rs_multi_pkg;

  localparam int DEF_TAG_W  = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_OP_W   = 6;

  typedef enum logic [DEF_OP_W-1:0] {
    OP_NOP = 6'd0,
    OP_ADD = 6'd1,
    OP_SUB = 6'd2,
    OP_AND = 6'd3,
    OP_OR  = 6'd4,
    OP_XOR = 6'd5,
    OP_BEQ = 6'd16,
    OP_BNE = 6'd17
  } op_e;

  localparam op_e NOP = OP_NOP;

  // A producer tag of zero means the operand value is already present.
  localparam logic [DEF_TAG_W-1:0] ZERO_TAG = '0;

endpackage

// File: rtl/rs_multi_age_matrix.sv
// Age matrix for oldest-first selection: older[i][j] set means entry j was dispatched before entry i.
module rs_age_matrix #(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] free,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] oldest
);

  logic [DEPTH-1:0][DEPTH-1:0] older;

  // A newly allocated entry is younger than every other slot; relations to idle slots
  // are never consulted because only ready (busy) entries take part in selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      older <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (alloc[i])
            older[i][j] <= !alloc[j];
          else if (alloc[j] || free[j])
            older[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    oldest = '0;
    for (int i = 0; i < DEPTH; i++)
      oldest[i] = ready[i] && !(|(older[i] & ready));
  end

endmodule

// File: rtl/rs_multi.sv
// Reservation station with CDB wakeup, dispatch bypass and a registered issue slot.
// Define RS_OLDEST_FIRST_EN to issue the oldest ready entry instead of the lowest-index one.
module rs_multi
  import rs_multi_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int NCDB   = 2,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       in_disp_valid,
  output logic                       out_disp_ready,
  input  logic [OP_W-1:0]            in_disp_op,
  input  logic [TAG_W-1:0]           in_disp_rob_tag,
  input  logic [DATA_W-1:0]          in_disp_v1,
  input  logic [DATA_W-1:0]          in_disp_v2,
  input  logic [DATA_W-1:0]          in_disp_imm,
  input  logic [TAG_W-1:0]           in_disp_q1,
  input  logic [TAG_W-1:0]           in_disp_q2,
  input  logic [NCDB-1:0]            in_cdb_valid,
  input  logic [NCDB*TAG_W-1:0]      in_cdb_tag,
  input  logic [NCDB*DATA_W-1:0]     in_cdb_value,
  output logic                       out_issue_valid,
  input  logic                       in_issue_ready,
  output logic [OP_W-1:0]            out_issue_op,
  output logic [DATA_W-1:0]          out_issue_v1,
  output logic [DATA_W-1:0]          out_issue_v2,
  output logic [DATA_W-1:0]          out_issue_imm,
  output logic [TAG_W-1:0]           out_issue_rob_tag,
  output logic [$clog2(DEPTH+1)-1:0] out_count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [TAG_W-1:0] ZTAG = TAG_W'(ZERO_TAG);

  logic [DEPTH-1:0]             busy;
  logic [DEPTH-1:0][OP_W-1:0]   e_op;
  logic [DEPTH-1:0][TAG_W-1:0]  e_rob, e_q1, e_q2;
  logic [DEPTH-1:0][DATA_W-1:0] e_v1, e_v2, e_imm;

  logic [DEPTH-1:0][TAG_W-1:0]  w_q1, w_q2;
  logic [DEPTH-1:0][DATA_W-1:0] w_v1, w_v2;
  logic [TAG_W-1:0]             d_q1, d_q2;
  logic [DATA_W-1:0]            d_v1, d_v2;

  logic [DEPTH-1:0] ready, free_oh, alloc_oh, sel_oh, iss_oh;
  logic             disp_fire, issue_free, iss_go;

  logic [OP_W-1:0]   s_op;
  logic [TAG_W-1:0]  s_rob;
  logic [DATA_W-1:0] s_v1, s_v2, s_imm;

  // Snoop all CDB ports for one operand; iterating high to low lets the lowest port win.
  function automatic logic [TAG_W+DATA_W-1:0] snoop(input logic [TAG_W-1:0] q,
                                                    input logic [DATA_W-1:0] v);
    logic [TAG_W+DATA_W-1:0] r;
    r = {q, v};
    for (int k = NCDB-1; k >= 0; k--)
      if (in_cdb_valid[k] && in_cdb_tag[k*TAG_W +: TAG_W] != ZTAG &&
          in_cdb_tag[k*TAG_W +: TAG_W] == q)
        r = {ZTAG, in_cdb_value[k*DATA_W +: DATA_W]};
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {w_q1[i], w_v1[i]} = snoop(e_q1[i], e_v1[i]);
      {w_q2[i], w_v2[i]} = snoop(e_q2[i], e_v2[i]);
    end
    {d_q1, d_v1} = snoop(in_disp_q1, in_disp_v1);
    {d_q2, d_v2} = snoop(in_disp_q2, in_disp_v2);
  end

  always_comb begin
    ready = '0;
    for (int i = 0; i < DEPTH; i++)
      ready[i] = busy[i] && e_q1[i] == ZTAG && e_q2[i] == ZTAG;
  end

  // Slot choice and readiness both come from registered state, so a slot freed by
  // issue is not reused and a fresh dispatch is not issued in the same cycle.
  assign out_disp_ready = ~&busy;
  assign free_oh        = ~busy & (busy + DEPTH'(1));
  assign disp_fire      = rdy && !flush && in_disp_valid && out_disp_ready;
  assign alloc_oh       = disp_fire ? free_oh : '0;
  assign issue_free     = !out_issue_valid || in_issue_ready;
  assign iss_go         = rdy && !flush && issue_free;
  assign iss_oh         = iss_go ? sel_oh : '0;

`ifdef RS_OLDEST_FIRST_EN
  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk    (clk),
    .rst    (rst),
    .alloc  (alloc_oh),
    .free   (iss_oh),
    .ready  (ready),
    .oldest (sel_oh)
  );
`else
  assign sel_oh = ready & (~ready + DEPTH'(1));
`endif

  always_comb begin
    s_op  = '0;
    s_rob = '0;
    s_v1  = '0;
    s_v2  = '0;
    s_imm = '0;
    for (int i = 0; i < DEPTH; i++) begin
      s_op  = s_op  | ({OP_W{sel_oh[i]}}   & e_op[i]);
      s_rob = s_rob | ({TAG_W{sel_oh[i]}}  & e_rob[i]);
      s_v1  = s_v1  | ({DATA_W{sel_oh[i]}} & e_v1[i]);
      s_v2  = s_v2  | ({DATA_W{sel_oh[i]}} & e_v2[i]);
      s_imm = s_imm | ({DATA_W{sel_oh[i]}} & e_imm[i]);
    end
  end

  always_comb begin
    out_count = '0;
    for (int i = 0; i < DEPTH; i++)
      out_count = out_count + CNT_W'(busy[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy              <= '0;
      out_issue_valid   <= 1'b0;
      out_issue_op      <= OP_W'(NOP);
      out_issue_rob_tag <= '0;
      out_issue_v1      <= '0;
      out_issue_v2      <= '0;
      out_issue_imm     <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy            <= '0;
        out_issue_valid <= 1'b0;
      end else begin
        busy <= (busy & ~iss_oh) | alloc_oh;
        if (issue_free) begin
          out_issue_valid <= |sel_oh;
          if (|sel_oh) begin
            out_issue_op      <= s_op;
            out_issue_rob_tag <= s_rob;
            out_issue_v1      <= s_v1;
            out_issue_v2      <= s_v2;
            out_issue_imm     <= s_imm;
          end
        end
      end
    end
  end

  // Payload needs no reset: busy gates every use of it.
  always_ff @(posedge clk) begin
    if (rdy && !flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_oh[i]) begin
          e_op[i]  <= in_disp_op;
          e_rob[i] <= in_disp_rob_tag;
          e_imm[i] <= in_disp_imm;
          e_q1[i]  <= d_q1;
          e_v1[i]  <= d_v1;
          e_q2[i]  <= d_q2;
          e_v2[i]  <= d_v2;
        end else begin
          e_q1[i] <= w_q1[i];
          e_v1[i] <= w_v1[i];
          e_q2[i] <= w_q2[i];
          e_v2[i] <= w_v2[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_multi.sv
// Scoreboard bench for rs_multi: directed scenarios plus randomized traffic against a behavioural model.
module tb_rs_multi;
  localparam int DEPTH = 16, NCDB = 2, TAG_W = 4, DATA_W = 32, OP_W = 6;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst, rdy, flush, in_disp_valid, out_disp_ready, out_issue_valid, in_issue_ready;
  logic [OP_W-1:0] in_disp_op, out_issue_op;
  logic [TAG_W-1:0] in_disp_rob_tag, in_disp_q1, in_disp_q2, out_issue_rob_tag;
  logic [DATA_W-1:0] in_disp_v1, in_disp_v2, in_disp_imm, out_issue_v1, out_issue_v2, out_issue_imm;
  logic [NCDB-1:0] in_cdb_valid;
  logic [NCDB*TAG_W-1:0] in_cdb_tag;
  logic [NCDB*DATA_W-1:0] in_cdb_value;
  logic [CNT_W-1:0] out_count;

  always #5 clk = ~clk;

  rs_multi #(.DEPTH(DEPTH), .NCDB(NCDB), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_disp_valid(in_disp_valid), .out_disp_ready(out_disp_ready),
    .in_disp_op(in_disp_op), .in_disp_rob_tag(in_disp_rob_tag),
    .in_disp_v1(in_disp_v1), .in_disp_v2(in_disp_v2), .in_disp_imm(in_disp_imm),
    .in_disp_q1(in_disp_q1), .in_disp_q2(in_disp_q2),
    .in_cdb_valid(in_cdb_valid), .in_cdb_tag(in_cdb_tag), .in_cdb_value(in_cdb_value),
    .out_issue_valid(out_issue_valid), .in_issue_ready(in_issue_ready),
    .out_issue_op(out_issue_op), .out_issue_v1(out_issue_v1), .out_issue_v2(out_issue_v2),
    .out_issue_imm(out_issue_imm), .out_issue_rob_tag(out_issue_rob_tag), .out_count(out_count)
  );

  typedef struct {
    bit busy;
    logic [OP_W-1:0] op;
    logic [TAG_W-1:0] rob, q1, q2;
    logic [DATA_W-1:0] v1, v2, imm;
    int seq;
  } ent_t;
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [TAG_W-1:0] rob;
    logic [DATA_W-1:0] v1, v2, imm;
  } iss_t;

  ent_t m[DEPTH];
  bit   m_iv = 0;
  iss_t m_ir = '0;
  int   m_seq = 0;
  iss_t exp_q[$];
  int   n_tests = 0, n_fail = 0;
  bit   done = 0, chk_en = 0, prev_valid = 0, prev_took = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void wake(input logic [TAG_W-1:0] qi, input logic [DATA_W-1:0] vi,
                               output logic [TAG_W-1:0] qo, output logic [DATA_W-1:0] vo);
    qo = qi; vo = vi;
    for (int k = 0; k < NCDB; k++)
      if (qo != 0 && in_cdb_valid[k] && in_cdb_tag[k*TAG_W +: TAG_W] == qo) begin
        vo = in_cdb_value[k*DATA_W +: DATA_W];
        qo = '0;
      end
  endfunction

  // One clock edge of the reference station, evaluated from the inputs held across the edge.
  task automatic model_step();
    int slot = -1, pick = -1;
    logic [TAG_W-1:0] q;
    logic [DATA_W-1:0] v;
    iss_t e;
    if (rst || (rdy && flush)) begin
      foreach (m[i]) m[i].busy = 0;
      m_iv = 0;
      return;
    end
    if (!rdy) return;
    foreach (m[i]) if (!m[i].busy && slot < 0) slot = i;
    foreach (m[i])
      if (m[i].busy && m[i].q1 == 0 && m[i].q2 == 0) begin
`ifdef RS_OLDEST_FIRST_EN
        if (pick < 0 || m[i].seq < m[pick].seq) pick = i;
`else
        if (pick < 0) pick = i;
`endif
      end
    if (!m_iv || in_issue_ready) begin
      m_iv = pick >= 0;
      if (pick >= 0) begin
        e.op = m[pick].op; e.rob = m[pick].rob;
        e.v1 = m[pick].v1; e.v2 = m[pick].v2; e.imm = m[pick].imm;
        m_ir = e;
        exp_q.push_back(e);
        m[pick].busy = 0;
      end
    end
    foreach (m[i])
      if (m[i].busy) begin
        wake(m[i].q1, m[i].v1, q, v); m[i].q1 = q; m[i].v1 = v;
        wake(m[i].q2, m[i].v2, q, v); m[i].q2 = q; m[i].v2 = v;
      end
    if (in_disp_valid && slot >= 0) begin
      m[slot].busy = 1; m[slot].op = in_disp_op; m[slot].rob = in_disp_rob_tag;
      m[slot].imm = in_disp_imm; m[slot].seq = m_seq++;
      wake(in_disp_q1, in_disp_v1, q, v); m[slot].q1 = q; m[slot].v1 = v;
      wake(in_disp_q2, in_disp_v2, q, v); m[slot].q2 = q; m[slot].v2 = v;
    end
  endtask

  task automatic mon_cycle();
    int cnt = 0;
    bit anyfree = 0;
    iss_t act, e;
    foreach (m[i]) begin
      cnt += int'(m[i].busy);
      if (!m[i].busy) anyfree = 1;
    end
    check("count", 128'(out_count), 128'(cnt));
    check("disp_ready", 128'(out_disp_ready), 128'(anyfree));
    check("issue_valid", 128'(out_issue_valid), 128'(m_iv));
    act.op = out_issue_op; act.rob = out_issue_rob_tag;
    act.v1 = out_issue_v1; act.v2 = out_issue_v2; act.imm = out_issue_imm;
    if (out_issue_valid) begin
      if (!prev_valid || prev_took) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL issue_data: got %0h expected nothing pending", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL issue_data: got %0h expected %0h", act, e);
          end
        end
      end else begin
        check("issue_hold", 128'(act), 128'(m_ir));
      end
    end
    prev_valid = out_issue_valid;
    prev_took  = out_issue_valid && in_issue_ready && rdy && !flush && !rst;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    in_disp_valid = 0; in_cdb_valid = '0; flush = 0; rdy = 1;
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] rob,
                      input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2,
                      input logic [TAG_W-1:0] q1, input logic [TAG_W-1:0] q2);
    in_disp_valid = 1; in_disp_op = op; in_disp_rob_tag = rob;
    in_disp_v1 = v1; in_disp_v2 = v2; in_disp_imm = v1 ^ 32'h0F0F_0000;
    in_disp_q1 = q1; in_disp_q2 = q2;
  endtask

  task automatic cdb(input int k, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] val);
    in_cdb_valid[k] = 1;
    in_cdb_tag[k*TAG_W +: TAG_W] = tag;
    in_cdb_value[k*DATA_W +: DATA_W] = val;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1; idle(); in_issue_ready = 1;
    in_disp_op = '0; in_disp_rob_tag = '0; in_disp_v1 = '0; in_disp_v2 = '0; in_disp_imm = '0;
    in_disp_q1 = '0; in_disp_q2 = '0; in_cdb_tag = '0; in_cdb_value = '0;
    fork
      begin
        step(); step(); rst = 0; chk_en = 1;
        check("rst_valid", 128'(out_issue_valid), 128'(0));
        check("rst_op", 128'(out_issue_op), 128'(0));
        check("rst_fields", {out_issue_v1, out_issue_v2, out_issue_imm, out_issue_rob_tag}, 128'(0));
        check("rst_count", 128'(out_count), 128'(0));
        check("rst_disp_ready", 128'(out_disp_ready), 128'(1));

        // ready operands: busy after edge t, issue after t+1
        disp(6'd1, 4'd3, 32'd5, 32'd7, 0, 0); step(); in_disp_valid = 0;
        check("t1_count1", 128'(out_count), 128'(1));
        check("t1_early", 128'(out_issue_valid), 128'(0));
        step();
        check("t1_valid", 128'(out_issue_valid), 128'(1));
        check("t1_ops", {out_issue_v1, out_issue_v2, out_issue_rob_tag}, {32'd5, 32'd7, 4'd3});
        check("t1_count0", 128'(out_count), 128'(0));
        step();
        check("t1_drained", 128'(out_issue_valid), 128'(0));

        // wakeup via CDB port 1
        disp(6'd2, 4'd5, 32'd0, 32'd1, 4'd4, 0); step(); in_disp_valid = 0;
        cdb(1, 4'd4, 32'hDEAD); step(); idle();
        check("t2_wait", 128'(out_issue_valid), 128'(0));
        step();
        check("t2_valid", 128'(out_issue_valid), 128'(1));
        check("t2_v1", 128'(out_issue_v1), 128'(32'hDEAD));
        step();

        // dispatch bypass from same-cycle broadcast
        disp(6'd1, 4'd6, 32'h11, 32'h0, 0, 4'd6); cdb(0, 4'd6, 32'h55); step(); idle();
        step();
        check("t3_valid", 128'(out_issue_valid), 128'(1));
        check("t3_v2", 128'(out_issue_v2), 128'(32'h55));
        step();

        // fill everything waiting on tag 9, then release
        for (int i = 0; i < DEPTH; i++) begin
          disp(6'd3, 4'((i % 15) + 1), 32'(i), 32'(i * 3), 4'd9, 4'd9); step();
        end
        in_disp_valid = 0;
        check("fill_ready", 128'(out_disp_ready), 128'(0));
        check("fill_count", 128'(out_count), 128'(DEPTH));
        cdb(0, 4'd9, 32'h99); step(); idle();
        check("fill_woken", 128'(out_count), 128'(DEPTH));
        for (int k = 1; k <= DEPTH; k++) begin
          step();
          check("drain_count", 128'(out_count), 128'(DEPTH - k));
        end
        step(); step();

        // back-pressure holds the first issued instruction
        in_issue_ready = 0;
        for (int i = 0; i < 3; i++) begin
          disp(6'd4, 4'(i + 1), 32'(100 + i), 32'd0, 0, 0); step();
        end
        in_disp_valid = 0;
        for (int c = 0; c < 5; c++) begin
          step();
          check("bp_tag", {out_issue_valid, out_issue_rob_tag}, {1'b1, 4'd1});
        end
        in_issue_ready = 1;
        for (int c = 0; c < 4; c++) step();

        // flush with a live issue register and 5 busy entries
        in_issue_ready = 0;
        for (int i = 0; i < 6; i++) begin
          disp(6'd5, 4'(i + 1), 32'(i), 32'd0, 0, 0); step();
        end
        check("fl_pre", {out_issue_valid, 8'(out_count)}, {1'b1, 8'd5});
        flush = 1; disp(6'd5, 4'd7, 32'd77, 32'd0, 0, 0); step(); idle();
        check("fl_post", {out_issue_valid, out_disp_ready, 8'(out_count)}, {1'b1 ^ 1'b1, 1'b1, 8'd0});
        step();
        check("fl_dropped", 128'(out_count), 128'(0));
        in_issue_ready = 1;

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
          rdy = $urandom_range(0, 19) != 0;
          flush = $urandom_range(0, 99) == 0;
          in_issue_ready = $urandom_range(0, 3) != 0;
          in_disp_valid = 1'($urandom_range(0, 1));
          in_disp_op = 6'($urandom); in_disp_rob_tag = 4'($urandom_range(1, 15));
          in_disp_v1 = $urandom; in_disp_v2 = $urandom; in_disp_imm = $urandom;
          in_disp_q1 = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 7));
          in_disp_q2 = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 7));
          for (int k = 0; k < NCDB; k++) begin
            in_cdb_valid[k] = $urandom_range(0, 2) == 0;
            in_cdb_tag[k*TAG_W +: TAG_W] = 4'($urandom_range(0, 7));
            in_cdb_value[k*DATA_W +: DATA_W] = $urandom;
          end
          step();
        end
        idle(); in_issue_ready = 1;
        for (int t = 1; t < 8; t++) begin
          cdb(0, 4'(t), 32'(t * 1000)); step(); in_cdb_valid = '0;
        end
        for (int c = 0; c < 40; c++) step();
        check("final_empty", {out_issue_valid, 8'(out_count)}, {1'b0, 8'd0});
        check("final_queue", 128'(exp_q.size()), 128'(0));
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (chk_en && !done) mon_cycle();
        end
      end
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_multi.md
# rs_multi

Parametrised reservation station for the Tomasulo out-of-order core. It sits between the decoder/dispatch stage and one execution unit (ALU or branch unit). It buffers up to DEPTH in-flight instructions and wakes up their operands from NCDB common data buses. When an instruction is ready, it is issued to the execution unit over a valid/ready handshake. On a branch misprediction, all entries are flushed.

## Interface
- DEPTH, 16: number of entries, ≥2
- NCDB, 2: number of CDB ports (ALU, LSB, ...)
- TAG_W, 4: ROB tag width; tag 0 means "value present"
- DATA_W, 32: operand/immediate width
- OP_W, 6: internal opcode width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state, outputs hold
- flush  in  1  misprediction clear
- in_disp_valid  in  1  dispatch request
- out_disp_ready  out  1  at least one free entry
- in_disp_op  in  OP_W  opcode
- in_disp_rob_tag  in  TAG_W  destination ROB tag, nonzero
- in_disp_v1, in_disp_v2, in_disp_imm  in  DATA_W each  operands/immediate
- in_disp_q1, in_disp_q2  in  TAG_W each  producer tags; 0 = valid
- in_cdb_valid  in  NCDB  per-port broadcast valid
- in_cdb_tag  in  NCDB*TAG_W  port k at [k*TAG_W +: TAG_W]
- in_cdb_value  in  NCDB*DATA_W  port k at [k*DATA_W +: DATA_W]
- out_issue_valid  out  1  issue register holds an instruction
- in_issue_ready  in  1  execution unit accepts
- out_issue_op  out  OP_W
- out_issue_v1, out_issue_v2, out_issue_imm  out  DATA_W
- out_issue_rob_tag  out  TAG_W
- out_count  out  $clog2(DEPTH+1)  number of occupied entries

## Operation
- Entry fields: busy, op, rob_tag, v1, v2, imm, q1, q2.
- An entry is ready when it is busy and q1 == q2 == 0.
- Dispatch fires when in_disp_valid && out_disp_ready && !flush.
  - The instruction is written into the lowest-index free entry.
  - out_disp_ready is combinational: it is `~&busy`.
- Wakeup: for each busy entry and each port k with in_cdb_valid[k] and a nonzero tag:
  - If q1 matches the tag, load v1 from that port and clear q1. The same rule applies to q2 independently.
  - Ports are expected to carry distinct tags. If two ports carry the same tag, the lowest port wins.
- Dispatch bypass: the operand tags of the instruction being dispatched are compared against the same-cycle CDB ports. On a match, the value is captured and the stored tag is 0, so no wakeup is lost.
- Issue:
  - The issue register is "free" when !out_issue_valid || in_issue_ready.
  - When it is free and some entry is ready, the selected entry is copied into the issue register, out_issue_valid goes to 1, and the entry's busy bit is cleared.
  - When it is free and no entry is ready, out_issue_valid goes to 0.
  - When it is not free, the issue register holds its contents.
- Simultaneous events:
  - An entry freed by issue is not reusable by dispatch in the same cycle.
  - An entry being dispatched is not issuable in the same cycle.
  - Wakeup and issue of different entries proceed in parallel.
- Flush (sampled when rdy):
  - All busy bits and out_issue_valid are cleared.
  - Dispatch and wakeup that cycle are discarded.
  - Flush has priority over everything except rst.
- Reset: all busy bits = 0. Outputs reset as follows:
  - out_issue_valid = 0
  - out_issue_op = NOP
  - out_issue_v1, out_issue_v2, out_issue_imm, out_issue_rob_tag = 0
  - out_count = 0
  - out_disp_ready = 1 (the cycle after reset)

## Timing
- Dispatch with both operands ready at edge t: the entry is busy after t, and out_issue_valid rises after edge t+1 if the issue register is free. Minimum latency is 2 edges.
- CDB broadcast in cycle t wakes an entry at edge t; that entry can reach the issue register at edge t+1.
- Back-pressure: while in_issue_ready = 0, every out_issue_* output is stable.
- Throughput: one issue per cycle when in_issue_ready stays high.
- out_count reflects registered busy bits: +1 per dispatch, −1 per issue, same-cycle net change, 0 after flush.

## Configuration
- RS_OLDEST_FIRST_EN defined: selection picks the oldest ready entry by dispatch order. An age matrix records, for each entry, which entries are older, and it is updated on dispatch.
- RS_OLDEST_FIRST_EN undefined: selection picks the lowest-index ready entry with a fixed priority encoder. The age matrix is not built.

## Structure
- Shared package constants:
  - NOP opcode
  - ZERO_TAG = 0
  - default TAG_W/DATA_W/OP_W (shared with the ROB, decoder and ALU)
- Sub-module rs_age_matrix (DEPTH×DEPTH bits):
  - inputs: alloc one-hot, free one-hot, ready vector
  - output: one-hot of the oldest ready entry
  - instantiated only under RS_OLDEST_FIRST_EN

## Test plan
- Reset, then dispatch op=ADD, v1=5, v2=7, q1=q2=0, rob_tag=3 -> out_issue_valid high 2 edges later with v1=5, v2=7, rob_tag=3; out_count goes 1 then 0.
- Dispatch with q1=4; then CDB port1 sends tag 4, value 0xDEAD -> issue 1 edge after the broadcast with v1=0xDEAD.
- Dispatch with q2=6 in the same cycle that CDB port0 sends tag 6, value 0x55 -> issues with v2=0x55; no hang.
- Fill DEPTH entries whose operands all wait on tag 9 -> out_disp_ready=0 and out_count=DEPTH; broadcast tag 9 -> all entries drain one per cycle.
- Hold in_issue_ready=0 with 3 ready entries for 5 cycles -> out_issue_* stable. Under RS_OLDEST_FIRST_EN the issue order follows dispatch order even after slots are reused out of index order.
- Assert flush while 5 entries are busy and out_issue_valid=1 -> next cycle busy=0, out_issue_valid=0, out_count=0; a dispatch in the flush cycle is dropped.
